// File: rtl/blockmem_2p_arb_pkg.sv
// Shared definitions for the two-requester arbitrated block memory.
//   state_t : controller states (CLEAR sweeps the array to zero, RUN serves requests)
//   N       : number of requesters sharing the memory
package blockmem_2p_arb_pkg;

    localparam int unsigned N = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/blockmem_2p.sv
// Simple dual-port block memory: port A writes with byte enables, port B reads
// with one cycle of registered latency. A read and a write to the same address
// on the same edge return the old contents.
//   clka, ena, wea, addra, dina : write port
//   clkb, enb, addrb, doutb     : read port
module blockmem_2p #(
    parameter  int G_DATAWIDTH = 32,
    parameter  int G_MEMDEPTH  = 1024,
    localparam int AW          = $clog2(G_MEMDEPTH),
    localparam int WW          = ((G_DATAWIDTH - 1) / 8) + 1
) (
    input  logic                   clka,
    input  logic                   ena,
    input  logic [WW-1:0]          wea,
    input  logic [AW-1:0]          addra,
    input  logic [G_DATAWIDTH-1:0] dina,
    input  logic                   clkb,
    input  logic                   enb,
    input  logic [AW-1:0]          addrb,
    output logic [G_DATAWIDTH-1:0] doutb
);

    logic [G_DATAWIDTH-1:0] mem [G_MEMDEPTH];
    logic [G_DATAWIDTH-1:0] wmask;

    // Expand byte enables to a bit mask; the top lane may be narrower than 8 bits.
    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < G_DATAWIDTH; i++) begin
            wmask[i] = wea[i / 8];
        end
    end

    always_ff @(posedge clka) begin
        if (ena) begin
            mem[addra] <= (mem[addra] & ~wmask) | (dina & wmask);
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/blockmem_2p_arb_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester is granted immediately; when
// both request, the one not granted most recently wins. The pointer only moves
// on a grant and after reset favours requester 0.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector, requester i at bit i
//   gnt      : one-hot (or zero) grant, combinational from req
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q = 1 means requester 1 was granted last, so requester 0 is favoured.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase

        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/blockmem_2p_arb.sv
// Block memory shared by two requesters. Writes go through memory port A and
// reads through port B, each with its own round-robin arbiter, so one write and
// one read may be accepted in the same cycle. After reset the array is
// optionally swept to zero before requests are accepted.
//   clk, rst   : clock, synchronous active-high reset
//   req_*      : per-requester request channel (valid/ready handshake)
//   rsp_valid  : per-requester read-data pulse, one cycle after the read handshake
//   rsp_rdata  : shared read data, qualified by rsp_valid
//   init_done  : high once the memory is ready for use
module blockmem_2p_arb
    import blockmem_2p_arb_pkg::*;
#(
    parameter  int G_DATAWIDTH = 32,
    parameter  int G_MEMDEPTH  = 1024,
    parameter  int G_CLEAR     = 1,
    localparam int AW          = $clog2(G_MEMDEPTH),
    localparam int WW          = ((G_DATAWIDTH - 1) / 8) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    output logic [N-1:0]             req_ready,
    input  logic [N-1:0]             req_we,
    input  logic [N*AW-1:0]          req_addr,
    input  logic [N*WW-1:0]          req_wstrb,
    input  logic [N*G_DATAWIDTH-1:0] req_wdata,
    output logic [N-1:0]             rsp_valid,
    output logic [G_DATAWIDTH-1:0]   rsp_rdata,
    output logic                     init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(G_MEMDEPTH - 1);

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             init_done_q;
    logic [N-1:0]     rsp_valid_q;

    logic             active;
    logic [N-1:0]     wr_elig;
    logic [N-1:0]     rd_elig;
    logic [N-1:0]     gnt_w;
    logic [N-1:0]     gnt_r;

    logic [AW-1:0]          addr_s  [N];
    logic [WW-1:0]          wstrb_s [N];
    logic [G_DATAWIDTH-1:0] wdata_s [N];

    logic                   mem_ena;
    logic [WW-1:0]          mem_wea;
    logic [AW-1:0]          mem_addra;
    logic [G_DATAWIDTH-1:0] mem_dina;
    logic                   mem_enb;
    logic [AW-1:0]          mem_addrb;
    logic [G_DATAWIDTH-1:0] mem_doutb;

    // Requests are only considered in RUN and never while reset is asserted,
    // so neither arbiter grants nor its pointer moves during reset.
    assign active = (state_q == RUN) && !rst;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            addr_s[i]  = req_addr[i*AW +: AW];
            wstrb_s[i] = req_wstrb[i*WW +: WW];
            wdata_s[i] = req_wdata[i*G_DATAWIDTH +: G_DATAWIDTH];
            wr_elig[i] = active && req_valid[i] && req_we[i];
            rd_elig[i] = active && req_valid[i] && !req_we[i];
        end
    end

    rr_arb2 u_arb_wr (
        .clk (clk),
        .rst (rst),
        .req (wr_elig),
        .gnt (gnt_w)
    );

    rr_arb2 u_arb_rd (
        .clk (clk),
        .rst (rst),
        .req (rd_elig),
        .gnt (gnt_r)
    );

    assign req_ready = gnt_w | gnt_r;

    // Port A is owned by the clear sweep in CLEAR and by the write arbiter in RUN.
    always_comb begin
        mem_ena   = 1'b0;
        mem_wea   = '0;
        mem_addra = '0;
        mem_dina  = '0;
        if (state_q == CLEAR && !rst) begin
            mem_ena   = 1'b1;
            mem_wea   = '1;
            mem_addra = cnt_q;
        end else if (gnt_w[1]) begin
            mem_ena   = 1'b1;
            mem_wea   = wstrb_s[1];
            mem_addra = addr_s[1];
            mem_dina  = wdata_s[1];
        end else if (gnt_w[0]) begin
            mem_ena   = 1'b1;
            mem_wea   = wstrb_s[0];
            mem_addra = addr_s[0];
            mem_dina  = wdata_s[0];
        end

        mem_enb   = |gnt_r;
        mem_addrb = gnt_r[1] ? addr_s[1] : addr_s[0];
    end

    blockmem_2p #(
        .G_DATAWIDTH (G_DATAWIDTH),
        .G_MEMDEPTH  (G_MEMDEPTH)
    ) u_mem (
        .clka  (clk),
        .ena   (mem_ena),
        .wea   (mem_wea),
        .addra (mem_addra),
        .dina  (mem_dina),
        .clkb  (clk),
        .enb   (mem_enb),
        .addrb (mem_addrb),
        .doutb (mem_doutb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (G_CLEAR != 0) ? CLEAR : RUN;
            cnt_q       <= '0;
            init_done_q <= (G_CLEAR == 0);
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= gnt_r;
            init_done_q <= (state_q == RUN);
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= (G_CLEAR != 0) ? CLEAR : RUN;
                end
            endcase
        end
    end

    // Masking with rst drops a response that would otherwise appear in the
    // same cycle reset is raised, so in-flight reads never report.
    assign rsp_valid = rsp_valid_q & {N{~rst}};
    assign init_done = init_done_q & ~rst;
    assign rsp_rdata = mem_doutb;

endmodule

// File: tb/tb_blockmem_2p_arb.sv
module tb_blockmem_2p_arb;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0]      req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*WW-1:0] req_wstrb = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            init_done;

    blockmem_2p_arb #(
        .G_DATAWIDTH (DW),
        .G_MEMDEPTH  (DEPTH),
        .G_CLEAR     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wstrb (req_wstrb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] data, input int at);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b expected none at cycle %0d", rsp_valid, cyc);
            end else begin
                exp_t e;
                logic [1:0] onehot;
                e = exp_q.pop_front();
                onehot = (e.id == 0) ? 2'b01 : 2'b10;
                check("rsp_id", 32'(rsp_valid), 32'(onehot));
                check("rsp_data", rsp_rdata, e.data);
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Single-requester transaction; call just after a negedge.
    task automatic txn(input int id, input bit we, input logic [3:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] expd);
        bit done = 0;
        req_valid[id] = 1'b1;
        req_we[id] = we;
        req_addr[id*AW +: AW] = addr;
        req_wstrb[id*WW +: WW] = strb;
        req_wdata[id*DW +: DW] = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            bit r;
            int hc;
            #1;
            r  = req_ready[id];
            hc = cyc;
            if (r && !we) push_exp(id, expd, hc + 1);
            @(posedge clk);
            if (r) done = 1;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL txn_timeout: got no ready expected ready for requester %0d", id);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_init();
        int k = 0;
        for (int j = 0; j < 100; j++) begin
            @(posedge clk);
            k++;
            #1;
            if (init_done) break;
        end
        check("init_latency", 32'(k), 32'd17);
    endtask

    initial begin
        // Reset with both requesters asserting reads: nothing must respond.
        rst = 1'b1;
        req_valid = 2'b11;
        req_we = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        rst = 1'b0;
        #1;
        check("clear_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        wait_init();

        // Both requesters reading continuously: grants alternate starting at 0.
        @(negedge clk);
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr = {4'd1, 4'd0};
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            #1;
            g = req_ready;
            check("rr_alternate", 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (g[0]) push_exp(0, 32'h0, cyc + 1);
            if (g[1]) push_exp(1, 32'h0, cyc + 1);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Cleared contents of every address.
        for (int a = 0; a < DEPTH; a++) begin
            txn(a % 2, 1'b0, 4'(a), 4'h0, 32'h0, 32'h0);
        end

        // Write from requester 0 concurrent with a read from requester 1.
        req_valid = 2'b11;
        req_we = 2'b01;
        req_addr = {4'd7, 4'd5};
        req_wstrb = {4'h0, 4'hF};
        req_wdata = {32'h0, 32'hDEADBEEF};
        #1;
        check("wr_rd_both_ready", 32'(req_ready), 32'h3);
        if (req_ready[1]) push_exp(1, 32'h0, cyc + 1);
        @(negedge clk);
        req_valid = 2'b00;
        txn(0, 1'b0, 4'd5, 4'h0, 32'h0, 32'hDEADBEEF);

        // Byte-strobe merge and same-cycle read-old-data.
        txn(0, 1'b1, 4'd3, 4'hF, 32'h11223344, 32'h0);
        req_valid = 2'b11;
        req_we = 2'b01;
        req_addr = {4'd3, 4'd3};
        req_wstrb = {4'h0, 4'b0010};
        req_wdata = {32'h0, 32'hAABBCCDD};
        #1;
        check("same_addr_both_ready", 32'(req_ready), 32'h3);
        if (req_ready[1]) push_exp(1, 32'h11223344, cyc + 1);
        @(negedge clk);
        req_valid = 2'b00;
        txn(1, 1'b0, 4'd3, 4'h0, 32'h0, 32'h1122CC44);
        txn(0, 1'b0, 4'd3, 4'h0, 32'h0, 32'h1122CC44);

        // Reset in the cycle after a read handshake: response is dropped.
        req_valid = 2'b01;
        req_we = 2'b00;
        req_addr = {4'd0, 4'd5};
        #1;
        check("pre_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        check("rst_drop_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rerst_init_done", 32'(init_done), 32'h0);
        check("rerst_rsp_valid", 32'(rsp_valid), 32'h0);
        req_valid = 2'b01;
        #1;
        check("reclear_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        wait_init();
        @(negedge clk);
        txn(0, 1'b0, 4'd5, 4'h0, 32'h0, 32'h0);
        txn(1, 1'b0, 4'd3, 4'h0, 32'h0, 32'h0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
